sha256_loop_sched: RTL



---
 rtl/sha256_loop_sched.sv | 119 +++++++++++
 1 files changed

// File: rtl/sha256_loop_sched.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sha256_loop_sched                                                |
// | Brief   : Round sequencer and block admission for a folded SHA-256 core.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sha256_loop_sched #(
  parameter int LOOP  = 4,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mid_wr,
  input  logic [255:0]     mid_in,
  output logic             mid_ready,
  input  logic             blk_valid,
  input  logic [511:0]     blk_data,
  input  logic [TAG_W-1:0] blk_tag,
  output logic             blk_ready,
  output logic             xf_feedback,
  output logic [5:0]       xf_cnt,
  output logic [255:0]     xf_state,
  output logic [511:0]     xf_input,
  input  logic [255:0]     xf_hash,
  output logic             hash_valid,
  output logic [255:0]     hash_data,
  output logic [TAG_W-1:0] hash_tag,
  output logic [6:0]       inflight
);

  localparam int c_N    = 64 / LOOP;
  localparam int c_PH_W = (LOOP > 1) ? $clog2(LOOP) : 1;

  logic [c_PH_W-1:0] r_ph;
  logic [c_N-1:0]    r_vld;
  logic [TAG_W-1:0]  r_tag [c_N];
  logic [255:0]      r_mid;
  logic              r_hash_valid;
  logic [TAG_W-1:0]  r_hash_tag;
  logic [6:0]        r_inflight;

  logic w_slot;
  logic w_accept;
  logic w_done;

  generate
    if (LOOP > 1) begin : g_ph_cnt
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_ph <= '0;
        end else if (r_ph == c_PH_W'(LOOP - 1)) begin
          r_ph <= '0;
        end else begin
          r_ph <= r_ph + c_PH_W'(1);
        end
      end
    end else begin : g_ph_fixed
      // Unfolded core: every cycle is a slot and the transform never feeds back.
      assign r_ph = '0;
    end
  endgenerate

  assign w_slot    = (r_ph == '0);
  assign blk_ready = w_slot & ~mid_wr;
  assign w_accept  = blk_valid & blk_ready;
  assign w_done    = w_slot & r_vld[c_N-1];
  // Any valid pipe entry, including one on its completion edge, blocks the load.
  assign mid_ready = mid_wr & (r_inflight == 7'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld        <= '0;
      for (int i = 0; i < c_N; i++) begin
        r_tag[i] <= '0;
      end
      r_hash_valid <= 1'b0;
      r_hash_tag   <= '0;
      r_inflight   <= 7'd0;
    end else begin
      r_hash_valid <= w_done;
      if (w_done) begin
        r_hash_tag <= r_tag[c_N-1];
      end
      if (w_slot) begin
        for (int i = c_N - 1; i > 0; i--) begin
          r_vld[i] <= r_vld[i-1];
          r_tag[i] <= r_tag[i-1];
        end
        r_vld[0] <= w_accept;
        r_tag[0] <= blk_tag;
      end
      if (w_accept && !w_done) begin
        r_inflight <= r_inflight + 7'd1;
      end else if (!w_accept && w_done) begin
        r_inflight <= r_inflight - 7'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mid <= '0;
    end else if (mid_ready) begin
      r_mid <= mid_in;
    end
  end

  assign xf_feedback = ~w_slot;
  assign xf_cnt      = 6'(r_ph);
  assign xf_state    = r_mid;
  assign xf_input    = blk_data;
  assign hash_valid  = r_hash_valid;
  assign hash_data   = xf_hash;
  assign hash_tag    = r_hash_tag;
  assign inflight    = r_inflight;

endmodule
`default_nettype wire
